// File: rtl/mem_responder_pkg.sv
// Shared definitions for the multicycle memory responder:
// access-size codes, FSM encoding and lane helpers.
package mem_responder_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   function automatic logic f3_bad(input logic [2:0] f3,
                                   input logic wr);
      if (wr)
         return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
      return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
   endfunction

   function automatic logic misaligned(input logic [2:0] f3,
                                       input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return off[0];
         2'b10:   return (off != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] word,
                                            input logic [1:0] off,
                                            input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    return {{24{b[7]}}, b};
         F3_BU:   return {24'd0, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_HU:   return {16'd0, h};
         default: return word;
      endcase
   endfunction

   function automatic logic [3:0] wr_lanes(input logic [2:0] f3,
                                           input logic [1:0] off);
      case (f3)
         F3_B:    return 4'b0001 << off;
         F3_H:    return off[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wr_data(input logic [2:0] f3,
                                           input logic [31:0] d);
      case (f3)
         F3_B:    return {4{d[7:0]}};
         F3_H:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Single-port word storage with byte-lane write enables
// and combinational read; contents are never reset.
module mem_array #(
   parameter int WORDS = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];

   // byte-lane writes into the addressed word
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be[i])
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Multicycle memory responder: accepts one request in IDLE,
// waits LATENCY cycles, then strobes a one-cycle response.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int WORDS   = 256,
   parameter int LATENCY = 2
) (
   input  logic        iClk,
   input  logic        iRst_n,
   input  logic        iMemRead,
   input  logic        iMemWrite,
   input  logic [31:0] iAddr,
   input  logic [31:0] iWData,
   input  logic [2:0]  iFunct3,
   output logic [31:0] oRData,
   output logic        oReady,
   output logic        oBusy,
   output logic        oErr
);

   localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [2:0] LAT_M1 =
      (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   state_t        state;
   logic [2:0]    count;
   logic [AW-1:0] idx_q;
   logic [1:0]    off_q;
   logic [31:0]   wdata_q;
   logic [2:0]    f3_q;
   logic          write_q;
   logic [31:0]   rdata_q;
   logic          ready_q;
   logic          err_q;
   logic          busy_q;

   logic [AW-1:0] cur_idx;
   logic [1:0]    cur_off;
   logic [2:0]    cur_f3;
   logic [31:0]   mem_rd;
   logic [31:0]   ext_data;
   logic [3:0]    mem_be;
   logic          req_bad;

   // in IDLE the live request addresses storage, otherwise the latched one
   always_comb begin
      cur_idx = idx_q;
      cur_off = off_q;
      cur_f3  = f3_q;
      if (state == ST_IDLE) begin
         cur_idx = iAddr[AW+1:2];
         cur_off = iAddr[1:0];
         cur_f3  = iFunct3;
      end
   end

   // classify the incoming request as illegal
   always_comb begin
      req_bad = (iMemRead & iMemWrite)
              | misaligned(iFunct3, iAddr[1:0])
              | f3_bad(iFunct3, iMemWrite)
              | ({2'b00, iAddr[31:2]} >= 32'(WORDS));
   end

   assign ext_data = load_ext(mem_rd, cur_off, cur_f3);
   assign mem_be   = (state == ST_RESP && write_q)
                   ? wr_lanes(f3_q, off_q) : 4'b0000;

   mem_array #(
      .WORDS (WORDS),
      .AW    (AW)
   ) u_array (
      .clk   (iClk),
      .be    (mem_be),
      .addr  (cur_idx),
      .wdata (wr_data(f3_q, wdata_q)),
      .rdata (mem_rd)
   );

   // request FSM with registered response outputs
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state   <= ST_IDLE;
         count   <= 3'd0;
         idx_q   <= '0;
         off_q   <= 2'b00;
         wdata_q <= 32'd0;
         f3_q    <= 3'd0;
         write_q <= 1'b0;
         rdata_q <= 32'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (iMemRead | iMemWrite) begin
                  idx_q   <= iAddr[AW+1:2];
                  off_q   <= iAddr[1:0];
                  wdata_q <= iWData;
                  f3_q    <= iFunct3;
                  write_q <= iMemWrite;
                  busy_q  <= 1'b1;
                  if (req_bad) begin
                     state   <= ST_ERR;
                     ready_q <= 1'b1;
                     err_q   <= 1'b1;
                  end else if (LATENCY == 0) begin
                     state   <= ST_RESP;
                     ready_q <= 1'b1;
                     if (!iMemWrite)
                        rdata_q <= ext_data;
                  end else begin
                     state <= ST_WAIT;
                     count <= LAT_M1;
                  end
               end
            end
            ST_WAIT: begin
               if (count == 3'd0) begin
                  state   <= ST_RESP;
                  ready_q <= 1'b1;
                  if (!write_q)
                     rdata_q <= ext_data;
               end else begin
                  count <= count - 3'd1;
               end
            end
            ST_RESP, ST_ERR: begin
               state   <= ST_IDLE;
               ready_q <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign oRData = rdata_q;
   assign oReady = ready_q;
   assign oErr   = err_q;
   assign oBusy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: LATENCY=2 instance for the main sequence,
// LATENCY=0 instance for zero-wait and held-request behaviour.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        rd, wr, rd0, wr0;
   logic [31:0] addr, wdat, addr0, wdat0;
   logic [2:0]  f3, f30;
   logic [31:0] rdata, rdata0;
   logic        ready, busy, err, ready0, busy0, err0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_responder #(.WORDS(256), .LATENCY(2)) dut (
      .iClk      (clk),
      .iRst_n    (rst_n),
      .iMemRead  (rd),
      .iMemWrite (wr),
      .iAddr     (addr),
      .iWData    (wdat),
      .iFunct3   (f3),
      .oRData    (rdata),
      .oReady    (ready),
      .oBusy     (busy),
      .oErr      (err)
   );

   mem_responder #(.WORDS(256), .LATENCY(0)) dut0 (
      .iClk      (clk),
      .iRst_n    (rst_n),
      .iMemRead  (rd0),
      .iMemWrite (wr0),
      .iAddr     (addr0),
      .iWData    (wdat0),
      .iFunct3   (f30),
      .oRData    (rdata0),
      .oReady    (ready0),
      .oBusy     (busy0),
      .oErr      (err0)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit z, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f);
      if (z) begin
         rd0 = r; wr0 = w; addr0 = a; wdat0 = d; f30 = f;
      end else begin
         rd = r; wr = w; addr = a; wdat = d; f3 = f;
      end
   endtask

   // issue one request; lat = cycle (1-based) after acceptance with oReady
   task automatic op(input string tag, input bit z,
                     input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f,
                     input int exp_lat, input logic exp_err,
                     input bit chk_data, input logic [31:0] exp_data);
      int lat;
      @(negedge clk);
      drive(z, r, w, a, d, f);
      @(posedge clk);
      #1;
      drive(z, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      lat = 1;
      while (!(z ? ready0 : ready) && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_err"}, {31'd0, z ? err0 : err}, {31'd0, exp_err});
      if (chk_data)
         check({tag, "_data"}, z ? rdata0 : rdata, exp_data);
      @(posedge clk);
      #1;
      check({tag, "_drop"}, {30'd0, z ? ready0 : ready,
                             z ? busy0 : busy}, 32'd0);
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      #12;
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_err",   {31'd0, err},   32'd0);
      check("rst_busy",  {31'd0, busy},  32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst0_out",  {rdata0[0], ready0, busy0, err0}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      op("sw10",  0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 3, 0, 0, 0);
      op("lw10",  0, 1, 0, 32'h10, 0, 3'b010, 3, 0, 1, 32'hDEADBEEF);
      op("sb11",  0, 0, 1, 32'h11, 32'h80, 3'b000, 3, 0, 0, 0);
      op("lb11",  0, 1, 0, 32'h11, 0, 3'b000, 3, 0, 1, 32'hFFFFFF80);
      op("lbu11", 0, 1, 0, 32'h11, 0, 3'b100, 3, 0, 1, 32'h00000080);
      op("lw10b", 0, 1, 0, 32'h10, 0, 3'b010, 3, 0, 1, 32'hDEAD80EF);
      op("lh12",  0, 1, 0, 32'h12, 0, 3'b001, 3, 0, 1, 32'hFFFFDEAD);
      op("lhu12", 0, 1, 0, 32'h12, 0, 3'b101, 3, 0, 1, 32'h0000DEAD);
      op("lw12",  0, 1, 0, 32'h12, 0, 3'b010, 1, 1, 1, 32'h0000DEAD);
      op("sh13",  0, 0, 1, 32'h13, 32'hFFFF, 3'b001, 1, 1, 1,
         32'h0000DEAD);
      op("lw10c", 0, 1, 0, 32'h10, 0, 3'b010, 3, 0, 1, 32'hDEAD80EF);
      op("both",  0, 1, 1, 32'h10, 32'h1, 3'b010, 1, 1, 1,
         32'hDEAD80EF);
      op("oob",   0, 1, 0, 32'h400, 0, 3'b010, 1, 1, 0, 0);
      op("rf3",   0, 1, 0, 32'h10, 0, 3'b011, 1, 1, 0, 0);
      op("wf3",   0, 0, 1, 32'h10, 32'h1, 3'b100, 1, 1, 0, 0);
      op("lw10d", 0, 1, 0, 32'h10, 0, 3'b010, 3, 0, 1, 32'hDEAD80EF);
      op("sw20z", 0, 0, 1, 32'h20, 32'h0, 3'b010, 3, 0, 0, 0);

      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h12345678, 3'b010);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      check("wait_busy", {31'd0, busy}, 32'd1);
      check("pre_rdata", rdata, 32'hDEAD80EF);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out", {29'd0, ready, busy, err}, 32'd0);
      check("mid_rst_rdata", rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      op("lw20",  0, 1, 0, 32'h20, 0, 3'b010, 3, 0, 1, 32'h0);

      op("z_sw8", 1, 0, 1, 32'h8, 32'h55AA0FF0, 3'b010, 1, 0, 0, 0);
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, 32'h8, 32'd0, 3'b010);
      @(posedge clk);
      #1;
      check("z_resp", {31'd0, ready0}, 32'd1);
      check("z_data", rdata0, 32'h55AA0FF0);
      @(posedge clk);
      #1;
      check("z_idle", {30'd0, ready0, busy0}, 32'd0);
      @(posedge clk);
      #1;
      check("z_reacc", {31'd0, ready0}, 32'd1);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
      @(posedge clk);
      #1;
      check("z_end", {31'd0, ready0}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
